// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel FSM state encodings.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write channel FSM
  localparam logic W_IDLE = 1'b0;
  localparam logic W_RESP = 1'b1;

  // Read channel FSM
  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register bank: strobe-masked synchronous write port, combinational read port,
// and a flattened view of every register.
module axi4_lite_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_we,
  input  logic [IDX_W-1:0]               i_widx,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
  input  logic [IDX_W-1:0]               i_ridx,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Clear on reset; otherwise update only the strobed bytes of the addressed register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_regs[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_regs[i_ridx];

  // Flatten the bank so reg i sits at bits [i*DATA_WIDTH +: DATA_WIDTH]
  always_comb begin
    o_regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      o_regs[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
    end
  end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite responder over a bank of memory-mapped registers. Independent write
// (AW/W/B) and read (AR/R) channel FSMs; out-of-range accesses get SLVERR.
module axi4_lite_slave
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_REGS      = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDRESS_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDRESS_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(NUM_REGS);

  // Write channel state
  logic                     r_wstate;
  logic                     r_aw_held;
  logic                     r_w_held;
  logic [ADDRESS_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [STRB_W-1:0]        r_wstrb;
  logic [1:0]               r_bresp;

  // Read channel state
  logic                     r_rstate;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [1:0]               r_rresp;

  logic                     w_aw_hs;
  logic                     w_w_hs;
  logic                     w_commit;
  logic [ADDRESS_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic [STRB_W-1:0]        w_wstrb;
  logic [ADDRESS_WIDTH-1:0] w_wr_word;
  logic [IDX_W-1:0]         w_wr_idx;
  logic                     w_wr_oor;

  logic                     w_ar_hs;
  logic [ADDRESS_WIDTH-1:0] w_rd_word;
  logic [IDX_W-1:0]         w_rd_idx;
  logic                     w_rd_oor;
  logic [DATA_WIDTH-1:0]    w_rf_rdata;

  // READY outputs come only from state and holding flags
  assign S_AXI_AWREADY = (r_wstate == W_IDLE) && !r_aw_held;
  assign S_AXI_WREADY  = (r_wstate == W_IDLE) && !r_w_held;
  assign S_AXI_ARREADY = (r_rstate == R_IDLE);

  assign S_AXI_BVALID  = (r_wstate == W_RESP);
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = (r_rstate == R_DATA);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;

  assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;

  // A held beat takes priority; otherwise use the beat handshaking this cycle
  assign w_waddr = r_aw_held ? r_awaddr : S_AXI_AWADDR;
  assign w_wdata = r_w_held  ? r_wdata  : S_AXI_WDATA;
  assign w_wstrb = r_w_held  ? r_wstrb  : S_AXI_WSTRB;

  assign w_commit = (r_wstate == W_IDLE) &&
                    (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  // Word address: low bits index the bank, anything above it is out of range
  assign w_wr_word = w_waddr >> ADDR_LSB;
  assign w_wr_idx  = w_wr_word[IDX_W-1:0];
  assign w_wr_oor  = (w_wr_word >> IDX_W) != '0;

  assign w_ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_rd_word = S_AXI_ARADDR >> ADDR_LSB;
  assign w_rd_idx  = w_rd_word[IDX_W-1:0];
  assign w_rd_oor  = (w_rd_word >> IDX_W) != '0;

  axi4_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .i_clk   (ACLK),
    .i_rst_n (ARESETN),
    .i_we    (w_commit && !w_wr_oor),
    .i_widx  (w_wr_idx),
    .i_wdata (w_wdata),
    .i_wstrb (w_wstrb),
    .i_ridx  (w_rd_idx),
    .o_rdata (w_rf_rdata),
    .o_regs  (regs_out)
  );

  // Write FSM: collect AW and W in any order, commit once both are present, then hold B until accepted
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else if (r_wstate == W_IDLE) begin
      if (w_commit) begin
        r_wstate  <= W_RESP;
        r_bresp   <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= S_AXI_AWADDR;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= S_AXI_WDATA;
          r_wstrb  <= S_AXI_WSTRB;
        end
      end
    end else if (S_AXI_BREADY) begin
      r_wstate <= W_IDLE;
    end
  end

  // Read FSM: register data/response on AR, hold R until accepted
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (r_rstate == R_IDLE) begin
      if (w_ar_hs) begin
        r_rstate <= R_DATA;
        r_rdata  <= w_rd_oor ? '0 : w_rf_rdata;
        r_rresp  <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end else if (S_AXI_RREADY) begin
      r_rstate <= R_IDLE;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Self-checking bench for axi4_lite_slave: table of write/read vectors plus
// hand-written multi-cycle sequences; B and R responses checked via scoreboards.
module tb_axi4_lite_slave;

  localparam int NREG = 16;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic [31:0]       S_AXI_AWADDR = '0;
  logic              S_AXI_AWVALID = 1'b0;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA = '0;
  logic [3:0]        S_AXI_WSTRB = '0;
  logic              S_AXI_WVALID = 1'b0;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY = 1'b1;
  logic [31:0]       S_AXI_ARADDR = '0;
  logic              S_AXI_ARVALID = 1'b0;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY = 1'b1;
  logic [NREG*32-1:0] regs_out;

  axi4_lite_slave #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .NUM_REGS      (NREG)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .regs_out      (regs_out)
  );

  always #5 ACLK = ~ACLK;

  int n_pass  = 0;
  int n_total = 0;
  int n_bresp = 0;

  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [31:0] model [NREG];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s_reg%0d", tag, i), {32'h0, regs_out[i*32 +: 32]}, {32'h0, model[i]});
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [3:0] idx;
    idx = addr[5:2];
    if ((addr >> 6) == 0)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((bq.size() != 0 || rq.size() != 0) && t < 50) begin
      @(posedge ACLK);
      t++;
    end
    check("drain", 64'(bq.size() + rq.size()), 64'd0);
    bq.delete();
    rq.delete();
    #1;
  endtask

  // Scoreboard: pop expectations when the DUT completes a B or R handshake
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        n_bresp++;
        if (bq.size() == 0) check("b_unexpected", 64'd1, 64'd0);
        else check("bresp", {62'h0, S_AXI_BRESP}, {62'h0, bq.pop_front()});
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) check("r_unexpected", 64'd1, 64'd0);
        else begin
          logic [33:0] e;
          e = rq.pop_front();
          check("rdata", {32'h0, S_AXI_RDATA}, {32'h0, e[33:2]});
          check("rresp", {62'h0, S_AXI_RRESP}, {62'h0, e[1:0]});
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    int t = 0;
    logic aw, w;
    @(posedge ACLK); #1;
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    bq.push_back(exp_resp);
    model_write(addr, data, strb);
    while ((S_AXI_AWVALID || S_AXI_WVALID) && t < 20) begin
      @(negedge ACLK);
      aw = S_AXI_AWVALID && S_AXI_AWREADY;
      w  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw) S_AXI_AWVALID = 1'b0;
      if (w)  S_AXI_WVALID = 1'b0;
      t++;
    end
    check("aw_w_accept", {62'h0, S_AXI_AWVALID, S_AXI_WVALID}, 64'd0);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    wait_drain();
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [1:0] exp_resp, input logic [31:0] exp_data);
    int t = 0;
    logic ar;
    @(posedge ACLK); #1;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    rq.push_back({exp_data, exp_resp});
    while (S_AXI_ARVALID && t < 20) begin
      @(negedge ACLK);
      ar = S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (ar) S_AXI_ARVALID = 1'b0;
      t++;
    end
    check("ar_accept", {63'h0, S_AXI_ARVALID}, 64'd0);
    S_AXI_ARVALID = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = '0;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_000C, 32'h0000_000A, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h0000_000A};
    vecs[4]  = '{1'b1, 32'h0000_003C, 32'hFFFF_FFFF, 4'h3, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 2'b00, 32'h0000_FFFF};
    vecs[6]  = '{1'b1, 32'h0000_0007, 32'h0000_0055, 4'h1, 2'b00, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0005, 32'h0,         4'h0, 2'b00, 32'hDEAD_BE55};
    vecs[8]  = '{1'b0, 32'h0000_0400, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_003E, 32'hAB00_0000, 4'h8, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 2'b00, 32'hAB00_FFFF};
    vecs[13] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h0022_0044};
    vecs[14] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[15] = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 2'b10, 32'h0};

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_bvalid_rvalid", {62'h0, S_AXI_BVALID, S_AXI_RVALID}, 64'd0);
    check("rst_rdata", {32'h0, S_AXI_RDATA}, 64'd0);
    check("rst_resps", {60'h0, S_AXI_BRESP, S_AXI_RRESP}, 64'd0);
    check("rst_regs_or", {63'h0, |regs_out}, 64'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("idle_readies", {61'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'h7);

    // W two cycles ahead of AW: reg2 with WSTRB 0101
    begin
      int b_before;
      b_before = n_bresp;
      @(posedge ACLK); #1;
      S_AXI_WDATA = 32'h1122_3344; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      check("wfirst_wready", {63'h0, S_AXI_WREADY}, 64'd1);
      @(posedge ACLK); #1;
      S_AXI_WVALID = 1'b0;
      @(negedge ACLK);
      check("wfirst_held_readies", {62'h0, S_AXI_WREADY, S_AXI_AWREADY}, 64'b01);
      check("wfirst_no_b_yet", {63'h0, S_AXI_BVALID}, 64'd0);
      @(posedge ACLK); #1;
      S_AXI_AWADDR = 32'h0000_0008; S_AXI_AWVALID = 1'b1;
      bq.push_back(2'b00);
      model_write(32'h0000_0008, 32'h1122_3344, 4'b0101);
      @(negedge ACLK);
      check("wfirst_awready", {63'h0, S_AXI_AWREADY}, 64'd1);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      wait_drain();
      repeat (2) @(negedge ACLK);
      check("wfirst_one_b", 64'(n_bresp - b_before), 64'd1);
      check("wfirst_reg2", {32'h0, regs_out[2*32 +: 32]}, 64'h0022_0044);
    end

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
        check_regs($sformatf("v%0d", i));
      end else begin
        axi_read(vecs[i].addr, vecs[i].resp, vecs[i].rdata);
      end
    end

    // BREADY held low for 5 cycles
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    S_AXI_AWADDR = 32'h0000_0010; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    bq.push_back(2'b00);
    model_write(32'h0000_0010, 32'h1234_5678, 4'hF);
    @(negedge ACLK);
    check("bp_accept", {62'h0, S_AXI_AWREADY, S_AXI_WREADY}, 64'b11);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      check($sformatf("bp_hold%0d", c),
            {59'h0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}, 64'b10000);
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b1;
    wait_drain();
    axi_write(32'h0000_0014, 32'h0BAD_CAFE, 4'hF, 2'b00);
    check_regs("bp");

    // Same-edge read capture and write commit on reg3 (0xA -> 0xB)
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 32'h0000_000C; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h0000_000B; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 32'h0000_000C; S_AXI_ARVALID = 1'b1;
    bq.push_back(2'b00);
    rq.push_back({32'h0000_000A, 2'b00});
    model_write(32'h0000_000C, 32'h0000_000B, 4'hF);
    @(negedge ACLK);
    check("same_edge_readies", {61'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'h7);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    wait_drain();
    axi_read(32'h0000_000C, 2'b00, 32'h0000_000B);

    // Reset while RVALID is pending with RREADY low
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    S_AXI_ARADDR = 32'h0000_0004; S_AXI_ARVALID = 1'b1;
    rq.push_back({32'hDEAD_BE55, 2'b00});
    @(negedge ACLK);
    check("rst_ar_ready", {63'h0, S_AXI_ARREADY}, 64'd1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    check("rst_pre_rvalid", {63'h0, S_AXI_RVALID}, 64'd1);
    check("rst_pre_rdata", {32'h0, S_AXI_RDATA}, 64'hDEAD_BE55);
    #2;
    ARESETN = 1'b0;
    #1;
    check("async_rvalid", {63'h0, S_AXI_RVALID}, 64'd0);
    check("async_regs_or", {63'h0, |regs_out}, 64'd0);
    check("async_rdata", {32'h0, S_AXI_RDATA}, 64'd0);
    rq.delete();
    for (int i = 0; i < NREG; i++) model[i] = '0;
    S_AXI_RREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("post_rst_arready", {63'h0, S_AXI_ARREADY}, 64'd1);
    axi_read(32'h0000_0004, 2'b00, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
